// File: rtl/pc_stack_4_if.sv
// Handshake bundle between the next-address mux/control side and the PC stage.
// The controller drives en/load/call/ret/D; the PC stage returns Q and stack flags.
interface pc_stack_4_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             stack_empty;
  logic             stack_full;
  logic             err;

  modport master (
    output en, load, call, ret, D,
    input  Q, stack_empty, stack_full, err
  );

  modport slave (
    input  en, load, call, ret, D,
    output Q, stack_empty, stack_full, err
  );
endinterface

// File: rtl/pc_stack_4.sv
// Program counter with a small LIFO return-address stack for CALL/RET.
// Optional macro PC_STACK_CIRC_EN: a full stack drops its oldest entry on call instead of flagging err.
module pc_stack_4 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  pc_stack_4_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] r_q;
  logic [SPW-1:0]   r_sp;
  logic             r_err;
  logic [WIDTH-1:0] r_stk [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic [WIDTH-1:0] w_inc;
  logic [AW-1:0]    w_top;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SPW'(DEPTH));
  assign w_inc   = r_q + WIDTH'(1);
  // At sp == DEPTH the low bits are zero, so the decrement wraps to DEPTH-1.
  assign w_top   = r_sp[AW-1:0] - AW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      r_sp  <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
    end else if (bus.en) begin
      if (bus.ret) begin
        if (w_empty) begin
          r_q   <= w_inc;
          r_err <= 1'b1;
        end else begin
          r_q  <= r_stk[w_top];
          r_sp <= r_sp - SPW'(1);
        end
      end else if (bus.call) begin
        r_q <= bus.D;
        if (!w_full) begin
          r_stk[r_sp[AW-1:0]] <= w_inc;
          r_sp                <= r_sp + SPW'(1);
        end else begin
`ifdef PC_STACK_CIRC_EN
          for (int i = 0; i < DEPTH-1; i++) r_stk[i] <= r_stk[i+1];
          r_stk[DEPTH-1] <= w_inc;
`else
          r_err <= 1'b1;
`endif
        end
      end else if (bus.load) begin
        r_q <= bus.D;
      end else begin
        r_q <= w_inc;
      end
    end
  end

  assign bus.Q           = r_q;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.err         = r_err;
endmodule

// File: doc/pc_stack_4.md
Name: pc_stack_4

Overview:
- Program-counter stage directly downstream of the 4-bit 2:1 next-address mux.
- Captures the mux output on jumps or calls; otherwise self-increments.
- Holds a small LIFO return-address stack so CALL/RET work in the 4-bit educational CPU datapath.
- Q feeds instruction memory and also returns to the mux A/B inputs.

Parameters:
WIDTH, 4, PC and address width (matches mux data width).
DEPTH, 4, number of return-address stack entries (power of two, ≥2).

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
en  input  1  1 = stage advances this cycle; 0 = stall, hold all state
load  input  1  jump: Q <= D
call  input  1  push return address, Q <= D
ret  input  1  pop: Q <= top of stack
D  input  WIDTH  target address from the upstream 2:1 mux
Q  output  WIDTH  current program counter
stack_empty  output  1  stack pointer == 0
stack_full  output  1  stack pointer == DEPTH
err  output  1  sticky flag: overflow or underflow occurred

Behaviour:
- Reset (reset == 0, asynchronous, independent of clk):
  - Q = 0, sp = 0, all stack entries = 0.
  - stack_empty = 1, stack_full = 0, err = 0.
- All state updates happen on the rising edge of clk while reset == 1.
- Priority each cycle: en == 0 hold > ret > call > load > increment.
- en == 0: Q, sp, stack contents and err unchanged. load/call/ret are ignored and not remembered.
- ret, stack not empty: Q <= stack[sp-1]; sp <= sp-1.
- ret, stack empty (underflow): Q <= Q+1; err <= 1; sp stays 0.
- call, stack not full:
  - stack[sp] <= Q+1 (mod 2^WIDTH).
  - sp <= sp+1.
  - Q <= D.
- call, stack full (overflow): Q <= D; push discarded; err <= 1; sp unchanged.
- load (no ret/call): Q <= D. Stack untouched.
- Otherwise: Q <= Q+1, wrapping from 2^WIDTH-1 to 0 with no flag.
- Latency: Q reflects any operation one clock after the enabling edge. There is no combinational path from inputs to Q.
- Flags are combinational decodes of registered sp and are valid in the same cycle as sp. err is registered.
- err is cleared only by reset.
- Push of Q+1 uses WIDTH-bit wrap: call at Q=0xF stores 0x0.
- sp width is clog2(DEPTH)+1 bits so that sp can represent DEPTH.
- Reset asserted mid-operation aborts any push or pop. No partial update survives.
- call and ret in the same cycle: ret wins; call is ignored with no push and no err.

Optional Feature:
PC_STACK_CIRC_EN
- Defined:
  - Stack is circular. A call when full overwrites the oldest entry: entries shift down, the new address goes to the top, and sp stays at DEPTH.
  - err is not set on overflow. Underflow still sets err.
- Undefined: overflow behaviour is exactly as in Behaviour (push discarded, err <= 1).

Test Plan:
1. Reset low while Q=0x7, asynchronously between edges -> Q=0x0, stack_empty=1, err=0 immediately, with no clock edge required.
2. en=1 only, 17 edges from reset -> Q goes 1,2,...,F,0,1. Then en=0 for 3 edges -> Q holds 0x1.
3. Q=0x3: call with D=0xA -> Q=0xA, stack_empty=0. Increment twice (Q=0xC), then ret -> Q=0x4, stack_empty=1.
4. Nested calls from Q=0x0 with D=0x5,0x8,0x2,0x9 -> stack_full=1. A fifth call with D=0xE -> Q=0xE and err=1; with PC_STACK_CIRC_EN, err=0.
   - Then 4 rets -> Q sequence 0x3, 0x9, 0x6, 0x1 (without the macro).
   - With the macro, the sequence starts from the overwritten top entry 0xA.
5. ret with empty stack at Q=0x6 -> Q=0x7, err=1, stack_empty=1. call and ret asserted together at Q=0x2 with empty stack -> ret wins: Q=0x3, err=1, no push.
6. load with D=0xB at Q=0x4 -> Q=0xB, stack unchanged. load, call and ret held while en=0 -> no change to Q or sp.
